// File: rtl/minifloat_accumulator.sv
// Sums N_TERMS minifloat products exactly in a signed fixed-point register and
// emits one round-to-nearest-even minifloat per group, in the multiplier's format.
module minifloat_accumulator #(
   parameter int unsigned n        = 8,
   parameter int unsigned exponent = 3,
   parameter int unsigned fraction = 4,
   parameter int unsigned N_TERMS  = 4,
   parameter int unsigned ACC_W    = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] input_z,
   input  logic         input_z_stb,
   output logic         in_ready,
   output logic [n-1:0] output_s,
   output logic         output_s_stb,
   output logic         drop_err
);

   localparam int unsigned BIAS  = (1 << (exponent - 1)) - 1;
   localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
   localparam int unsigned EW    = $clog2(ACC_W) + 2;
   localparam int unsigned FW1   = fraction + 1;
   localparam int          E_TOP = int'(ACC_W) - 1 - int'(fraction + BIAS - 1);
   localparam logic signed [EW-1:0] E_MIN_W = EW'(1 - int'(BIAS));
   localparam logic signed [EW-1:0] E_MAX_W = EW'(int'(1 << exponent) - 2 - int'(BIAS));
   localparam logic [n-1:0] NAN_W = {1'b1, {exponent{1'b1}}, 1'b1, {(fraction - 1){1'b0}}};

   typedef enum logic [2:0] {
      S_COLLECT, S_CONVERT, S_ADD, S_ABS, S_NORM, S_ROUND, S_PACK, S_OUT
   } state_e;

   state_e                 state_q;
   logic [n-1:0]           word_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   nan_q, pinf_q, ninf_q;
   logic                   sign_q, uflow_q;
   logic [ACC_W-1:0]       mag_q;
   logic signed [EW-1:0]   exp_q;
   logic [fraction-1:0]    frac_q;
   logic [n-1:0]           out_q;
   logic                   out_stb_q, in_ready_q, drop_q;

   logic [exponent-1:0]    fld_c;
   logic [fraction-1:0]    frc_c;
   logic                   is_spec_c, is_norm_c;
   logic [ACC_W-1:0]       term_mag_c, abs_c;
   logic [fraction-1:0]    kept_c;
   logic                   guard_c, sticky_c, rnd_up_c;
   logic [fraction:0]      rsum_c;

   // Term decode of the latched word and RNE increment of the normalised magnitude
   always_comb begin
      fld_c      = word_q[n-2:fraction];
      frc_c      = word_q[fraction-1:0];
      is_spec_c  = &fld_c;
      is_norm_c  = (fld_c != '0) && !is_spec_c;
      term_mag_c = ACC_W'({1'b1, frc_c}) << (fld_c - exponent'(1));
      abs_c      = acc_q[ACC_W-1] ? $unsigned(-acc_q) : $unsigned(acc_q);
      kept_c     = mag_q[ACC_W-2 -: fraction];
      guard_c    = mag_q[ACC_W-2-fraction];
      sticky_c   = |mag_q[ACC_W-3-fraction:0];
      rnd_up_c   = guard_c & (sticky_c | kept_c[0]);
      rsum_c     = {1'b0, kept_c} + FW1'(rnd_up_c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_COLLECT;
         word_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         nan_q      <= 1'b0;
         pinf_q     <= 1'b0;
         ninf_q     <= 1'b0;
         sign_q     <= 1'b0;
         uflow_q    <= 1'b0;
         mag_q      <= '0;
         exp_q      <= '0;
         frac_q     <= '0;
         out_q      <= '0;
         out_stb_q  <= 1'b0;
         in_ready_q <= 1'b1;
         drop_q     <= 1'b0;
      end else begin
         if (input_z_stb && (state_q != S_COLLECT)) drop_q <= 1'b1;
         case (state_q)
            S_COLLECT: begin
               if (input_z_stb) begin
                  word_q     <= input_z;
                  in_ready_q <= 1'b0;
                  state_q    <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               if (is_spec_c) begin
                  if (frc_c != '0)    nan_q  <= 1'b1;
                  else if (word_q[n-1]) ninf_q <= 1'b1;
                  else                pinf_q <= 1'b1;
               end
               state_q <= S_ADD;
            end
            S_ADD: begin
               if (is_norm_c)
                  acc_q <= word_q[n-1] ? acc_q - $signed(term_mag_c)
                                       : acc_q + $signed(term_mag_c);
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N_TERMS - 1)) begin
                  state_q <= S_ABS;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= S_COLLECT;
               end
            end
            S_ABS: begin
               sign_q  <= acc_q[ACC_W-1];
               mag_q   <= abs_c;
               exp_q   <= EW'(E_TOP);
               state_q <= S_NORM;
            end
            // exp_q tracks the leading-one position as the magnitude is shifted up
            S_NORM: begin
               if (mag_q == '0) begin
                  state_q <= S_PACK;
               end else if (mag_q[ACC_W-1]) begin
                  state_q <= S_ROUND;
               end else begin
                  mag_q <= mag_q << 1;
                  exp_q <= exp_q - EW'(1);
               end
            end
            S_ROUND: begin
               uflow_q <= (exp_q < E_MIN_W);
               frac_q  <= rsum_c[fraction-1:0];
               if (rsum_c[fraction]) exp_q <= exp_q + EW'(1);
               state_q <= S_PACK;
            end
            S_PACK: begin
               if (nan_q || (pinf_q && ninf_q))
                  out_q <= NAN_W;
               else if (pinf_q || ninf_q)
                  out_q <= {ninf_q, {exponent{1'b1}}, {fraction{1'b0}}};
               else if ((mag_q == '0) || uflow_q)
                  out_q <= '0;
               else if (exp_q > E_MAX_W)
                  out_q <= {sign_q, {exponent{1'b1}}, {fraction{1'b0}}};
               else
                  out_q <= {sign_q, exponent'(exp_q + EW'(BIAS)), frac_q};
               out_stb_q <= 1'b1;
               state_q   <= S_OUT;
            end
            S_OUT: begin
               out_stb_q  <= 1'b0;
               acc_q      <= '0;
               cnt_q      <= '0;
               nan_q      <= 1'b0;
               pinf_q     <= 1'b0;
               ninf_q     <= 1'b0;
               in_ready_q <= 1'b1;
               state_q    <= S_COLLECT;
            end
            default: state_q <= S_COLLECT;
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign output_s     = out_q;
   assign output_s_stb = out_stb_q;
   assign drop_err     = drop_q;

endmodule

// File: tb/tb_minifloat_accumulator.sv
// Scoreboard bench for minifloat_accumulator: expected sums are queued as each
// group's last term is driven and popped when output_s_stb appears.
module tb_minifloat_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] input_z = 8'h00;
   logic       input_z_stb = 1'b0;
   logic       in_ready;
   logic [7:0] output_s;
   logic       output_s_stb;
   logic       drop_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   minifloat_accumulator dut (
      .clk          (clk),
      .rst          (rst),
      .input_z      (input_z),
      .input_z_stb  (input_z_stb),
      .in_ready     (in_ready),
      .output_s     (output_s),
      .output_s_stb (output_s_stb),
      .drop_err     (drop_err)
   );

   // Reference: exact integer sum in 2^-6 units, then RNE to the 8-bit format
   function automatic logic [7:0] model_sum(input logic [7:0] w0, input logic [7:0] w1,
                                            input logic [7:0] w2, input logic [7:0] w3);
      logic [7:0] w[4];
      int s, a, pos, e, q, r, half, f, m;
      bit nan, pinf, ninf;
      w = '{w0, w1, w2, w3};
      s = 0; nan = 0; pinf = 0; ninf = 0;
      foreach (w[i]) begin
         f = int'(w[i][6:4]);
         m = int'(w[i][3:0]);
         if (f == 7) begin
            if (m != 0) nan = 1;
            else if (w[i][7]) ninf = 1;
            else pinf = 1;
         end else if (f != 0) begin
            s += (w[i][7] ? -1 : 1) * ((16 + m) << (f - 1));
         end
      end
      if (nan || (pinf && ninf)) return 8'hF8;
      if (pinf) return 8'h70;
      if (ninf) return 8'hF0;
      if (s == 0) return 8'h00;
      a = (s < 0) ? -s : s;
      pos = 0;
      while ((a >> (pos + 1)) != 0) pos++;
      e = pos - 6;
      if (e < -2) return 8'h00;
      q = a;
      if (pos >= 5) begin
         q = a >> (pos - 4);
         r = a - (q << (pos - 4));
         half = 1 << (pos - 5);
         if ((r > half) || ((r == half) && (q % 2 == 1))) q++;
      end
      if (q == 32) begin q = 16; e++; end
      if (e > 3) return (s < 0) ? 8'hF0 : 8'h70;
      return {(s < 0), 3'(e + 3), 4'(q - 16)};
   endfunction

   task automatic drive_term(input logic [7:0] w);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      input_z = w;
      input_z_stb = 1'b1;
      @(negedge clk);
      input_z_stb = 1'b0;
   endtask

   task automatic send_group(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3,
                             input logic [7:0] expv);
      drive_term(w0);
      drive_term(w1);
      drive_term(w2);
      exp_q.push_back(expv);
      drive_term(w3);
   endtask

   // Observes one result strobe (bounded) and pops its expected value
   task automatic get_result(output bit seen, output logic [7:0] val,
                             output bit one_cycle, output logic [7:0] expv);
      seen = 0; one_cycle = 0; val = 8'hxx; expv = 8'hxx;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (output_s_stb) begin
            seen = 1;
            val  = output_s;
         end
      end
      if (seen) begin
         @(negedge clk);
         one_cycle = !output_s_stb;
      end
      if (exp_q.size() > 0) expv = exp_q.pop_front();
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (output_s !== 8'h00) begin n_bad++; $display("FAIL reset_output_s: got %h want 00", output_s); end
      n_cmp++;
      if (output_s_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", output_s_stb); end
      n_cmp++;
      if (drop_err !== 1'b0) begin n_bad++; $display("FAIL reset_drop_err: got %b want 0", drop_err); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic;
      bit seen, one; logic [7:0] val, e;
      drive_term(8'h30);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready: got %b want 0", in_ready); end
      drive_term(8'h30);
      drive_term(8'h30);
      exp_q.push_back(8'h50);
      drive_term(8'h30);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL basic_sum: got %h (seen=%0b) want %h", val, seen, e); end
      n_cmp++;
      if (!one) begin n_bad++; $display("FAIL basic_stb_width: stb high more than one cycle or missing"); end
      n_cmp++;
      if (drop_err !== 1'b0) begin n_bad++; $display("FAIL basic_drop_err: got %b want 0", drop_err); end
   endtask

   task automatic test_cancel;
      bit seen, one; logic [7:0] val, e;
      send_group(8'h38, 8'hB8, 8'h30, 8'h30, 8'h40);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL cancel_two: got %h (seen=%0b) want %h", val, seen, e); end
      send_group(8'h38, 8'hB8, 8'h00, 8'h00, 8'h00);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL cancel_zero: got %h (seen=%0b) want %h", val, seen, e); end
   endtask

   task automatic test_rne;
      bit seen, one; logic [7:0] val, e;
      send_group(8'h61, 8'h10, 8'h00, 8'h00, 8'h62);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL rne_up: got %h (seen=%0b) want %h", val, seen, e); end
      send_group(8'h62, 8'h10, 8'h00, 8'h00, 8'h62);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL rne_tie_even: got %h (seen=%0b) want %h", val, seen, e); end
   endtask

   task automatic test_special;
      bit seen, one; logic [7:0] val, e;
      logic [7:0] t[4];
      send_group(8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h70);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL overflow_inf: got %h (seen=%0b) want %h", val, seen, e); end
      send_group(8'h70, 8'hF0, 8'h30, 8'h30, 8'hF8);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL inf_minus_inf: got %h (seen=%0b) want %h", val, seen, e); end
      for (int k = 0; k < 4; k++) begin
         t = '{8'h30, 8'h38, 8'hB0, 8'h40};
         t[k] = 8'hF8;
         send_group(t[0], t[1], t[2], t[3], 8'hF8);
         get_result(seen, val, one, e);
         n_cmp++;
         if (!seen || val !== e) begin n_bad++; $display("FAIL nan_slot%0d: got %h (seen=%0b) want %h", k, val, seen, e); end
      end
   endtask

   task automatic test_random;
      bit seen, one; logic [7:0] val, e;
      logic [7:0] t[4];
      for (int g = 0; g < 8; g++) begin
         foreach (t[i]) t[i] = {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6)), 4'($urandom_range(0, 15))};
         send_group(t[0], t[1], t[2], t[3], model_sum(t[0], t[1], t[2], t[3]));
         get_result(seen, val, one, e);
         n_cmp++;
         if (!seen || val !== e) begin
            n_bad++;
            $display("FAIL random_g%0d: terms %h %h %h %h got %h (seen=%0b) want %h", g, t[0], t[1], t[2], t[3], val, seen, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit seen, one; logic [7:0] val, e;
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      input_z = 8'h30; input_z_stb = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
      input_z = 8'h38;
      @(negedge clk);
      input_z_stb = 1'b0;
      n_cmp++;
      if (drop_err !== 1'b1) begin n_bad++; $display("FAIL b2b_drop_err: got %b want 1", drop_err); end
      drive_term(8'h30);
      drive_term(8'h30);
      exp_q.push_back(8'h50);
      drive_term(8'h30);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL b2b_sum: got %h (seen=%0b) want %h", val, seen, e); end
      n_cmp++;
      if (drop_err !== 1'b1) begin n_bad++; $display("FAIL b2b_drop_sticky: got %b want 1", drop_err); end
   endtask

   task automatic test_reset_mid;
      bit seen, one, stray; logic [7:0] val, e;
      drive_term(8'h30);
      drive_term(8'h30);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (output_s !== 8'h00) begin n_bad++; $display("FAIL midrst_output_s: got %h want 00", output_s); end
      n_cmp++;
      if (drop_err !== 1'b0) begin n_bad++; $display("FAIL midrst_drop_err: got %b want 0", drop_err); end
      @(negedge clk);
      rst = 1'b1;
      stray = 0;
      repeat (25) begin
         @(negedge clk);
         if (output_s_stb) stray = 1;
      end
      n_cmp++;
      if (stray) begin n_bad++; $display("FAIL midrst_no_stb: got stray output_s_stb want none"); end
      send_group(8'h30, 8'h30, 8'h30, 8'h30, 8'h50);
      get_result(seen, val, one, e);
      n_cmp++;
      if (!seen || val !== e) begin n_bad++; $display("FAIL midrst_sum: got %h (seen=%0b) want %h", val, seen, e); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cancel();
      test_rne();
      test_special();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
